// File: rtl/spi_slave_framed.sv
// SPI slave front-end: deserialises MSB-first {cmd[1:0], payload} frames sampled on clk,
// hands them to the RAM controller, and serialises read data back on MISO.
module spi_slave_framed #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [DATA_W+1:0]   rx_data,
  output logic                rx_valid,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TO_W    = $clog2(TX_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECV    = 3'd1;
  localparam logic [2:0] S_WAIT_TX = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [2:0]         r_state;
  // Holds the first FRAME_W-1 bits; the final bit comes straight from MOSI.
  logic [FRAME_W-2:0] r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [TO_W-1:0]    r_to;
  logic               r_miso;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_rd_seen;

  logic [FRAME_W-1:0] w_frame;
  logic [1:0]         w_cmd;
  logic               w_last;
  logic               w_abort;
  logic               w_tx_last;
  logic               w_to_expired;

  assign w_frame      = {r_shift, MOSI};
  assign w_cmd        = w_frame[FRAME_W-1:FRAME_W-2];
  assign w_last       = (r_cnt == CNT_W'(FRAME_W - 1));
  assign w_tx_last    = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_to_expired = (r_to == TO_W'(TX_TIMEOUT - 1));
  assign w_abort      = SS_n && ((r_state == S_RECV) || (r_state == S_WAIT_TX) ||
                                 (r_state == S_SEND));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_to        <= '0;
      r_miso      <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_seen   <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!SS_n) begin
              r_state <= S_RECV;
              r_cnt   <= '0;
            end
          end
          S_RECV: begin
            r_shift <= w_frame[FRAME_W-2:0];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
              r_rx_data <= w_frame;
              r_state   <= S_DONE;
              if (w_cmd == CMD_RD_DATA) begin
                if (r_rd_seen) begin
                  r_rx_valid <= 1'b1;
                  r_to       <= '0;
                  r_state    <= S_WAIT_TX;
                end else begin
                  r_frame_err <= 1'b1;
                end
              end else begin
                r_rx_valid <= 1'b1;
                if (w_cmd == CMD_RD_ADDR) r_rd_seen <= 1'b1;
              end
            end
          end
          S_WAIT_TX: begin
            // tx_valid takes priority over an expiring timeout on the same edge.
            if (tx_valid) begin
              r_shift <= {1'b0, tx_data};
              r_miso  <= tx_data[DATA_W-1];
              r_cnt   <= '0;
              r_state <= S_SEND;
            end else if (w_to_expired) begin
              r_frame_err <= 1'b1;
              r_rd_seen   <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_to <= r_to + 1'b1;
            end
          end
          S_SEND: begin
            if (w_tx_last) begin
              r_miso    <= 1'b0;
              r_rd_seen <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_miso  <= r_shift[DATA_W-2];
              r_shift <= r_shift << 1;
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
            r_miso <= 1'b0;
            if (SS_n) r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MISO      = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_framed.sv
// Scoreboard bench for spi_slave_framed: drivers push cycle-stamped expectations,
// a negedge monitor checks them against DUT outputs and flags unexpected pulses.
module tb_spi_slave_framed;

  localparam int DW = 8;
  localparam int FW = DW + 2;

  localparam int K_RX   = 0;
  localparam int K_ERR  = 1;
  localparam int K_MISO = 2;
  localparam int K_BUSY = 3;
  localparam int K_HOLD = 4;
  localparam int K_RST  = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [9:0]  d;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          frame_err;
  logic          busy;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  spi_slave_framed #(.DATA_W(DW), .TX_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor
  initial begin
    bit got_rx, got_err;
    forever begin
      @(negedge clk);
      got_rx  = 1'b0;
      got_err = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc < cyc) begin
          chk("stale_expectation", 10'(q[i].cyc), 10'(cyc));
          q.delete(i);
        end else if (q[i].cyc == cyc) begin
          case (q[i].kind)
            K_RX: begin
              chk("rx_valid", {9'd0, rx_valid}, 10'd1);
              chk("rx_data", rx_data, q[i].d);
              got_rx = 1'b1;
            end
            K_ERR: begin
              chk("frame_err", {9'd0, frame_err}, 10'd1);
              got_err = 1'b1;
            end
            K_MISO: chk("MISO", {9'd0, MISO}, q[i].d);
            K_BUSY: chk("busy", {9'd0, busy}, q[i].d);
            K_HOLD: chk("rx_data_hold", rx_data, q[i].d);
            default: begin
              chk("rst_ctrl", {6'd0, MISO, rx_valid, frame_err, busy}, 10'd0);
              chk("rst_rx_data", rx_data, 10'd0);
            end
          endcase
          q.delete(i);
        end
      end
      if (rx_valid && !got_rx)   chk("spurious_rx_valid", {9'd0, rx_valid}, 10'd0);
      if (frame_err && !got_err) chk("spurious_frame_err", {9'd0, frame_err}, 10'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int k, input logic [9:0] d);
    exp_t e;
    e.cyc = c; e.kind = k; e.d = d;
    q.push_back(e);
  endtask

  // Full frame; leaves SS_n low. Returns in the cycle the response is visible.
  task automatic frame(input logic [FW-1:0] f, input int k);
    int c0;
    c0 = cyc;
    push(c0 + 1 + FW, k, f);
    push(c0 + 1 + FW, K_MISO, 10'd0);
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < FW; i++) begin
      MOSI = f[FW-1-i];
      tick();
    end
    MOSI = 1'b0;
  endtask

  task automatic release_ss();
    push(cyc + 1, K_BUSY, 10'd0);
    SS_n = 1'b1;
    tick();
  endtask

  task automatic send_tx(input logic [DW-1:0] d, input int wait_cyc);
    int c;
    repeat (wait_cyc) tick();
    c = cyc;
    for (int k = 0; k < DW; k++) push(c + 1 + k, K_MISO, {9'd0, d[DW-1-k]});
    push(c + 1 + DW, K_MISO, 10'd0);
    push(c + 2 + DW, K_MISO, 10'd0);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~d;
    repeat (DW + 2) tick();
  endtask

  task automatic partial_abort(input logic [FW-1:0] f, input int nbits, input logic [9:0] hold);
    SS_n = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[FW-1-i];
      tick();
    end
    push(cyc + 1, K_ERR, 10'd0);
    push(cyc + 1, K_BUSY, 10'd0);
    push(cyc + 1, K_HOLD, hold);
    SS_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int r;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(); tick();
    push(cyc, K_RST, 10'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // cmd 11 with no preceding cmd 10
    frame(10'h3F0, K_ERR);
    release_ss();
    // write address, then write data with tx_valid held high (ignored)
    frame(10'h0A5, K_RX);
    release_ss();
    tx_valid = 1'b1; tx_data = 8'hFF;
    frame(10'h15C, K_RX);
    tx_valid = 1'b0; tx_data = '0;
    release_ss();
    // read pair; tx_valid lands on the timeout edge and must win
    frame(10'h203, K_RX);
    release_ss();
    frame(10'h300, K_RX);
    send_tx(8'hC3, 3);
    release_ss();
    // rd_addr_seen consumed by the completed read
    frame(10'h3A5, K_ERR);
    release_ss();
    // read pair with immediate tx_valid
    frame(10'h281, K_RX);
    release_ss();
    frame(10'h3FF, K_RX);
    send_tx(8'h5A, 0);
    release_ss();
    // timeout: no tx_valid
    frame(10'h2F0, K_RX);
    release_ss();
    frame(10'h300, K_RX);
    r = cyc;
    push(r + 3, K_BUSY, 10'd1);
    push(r + 4, K_ERR, 10'd0);
    push(r + 4, K_MISO, 10'd0);
    repeat (6) tick();
    release_ss();
    frame(10'h355, K_ERR);
    release_ss();
    // abort in RECV after 5 bits
    frame(10'h1E7, K_RX);
    release_ss();
    partial_abort(10'h2C3, 5, 10'h1E7);
    // abort during SEND
    frame(10'h201, K_RX);
    release_ss();
    frame(10'h302, K_RX);
    r = cyc;
    push(r + 1, K_MISO, 10'd1);
    push(r + 2, K_MISO, 10'd1);
    push(r + 3, K_MISO, 10'd1);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick(); tick();
    push(r + 4, K_MISO, 10'd0);
    push(r + 4, K_ERR, 10'd0);
    push(r + 4, K_BUSY, 10'd0);
    SS_n = 1'b1;
    tick(); tick();
    // async reset mid-SEND
    frame(10'h204, K_RX);
    release_ss();
    frame(10'h305, K_RX);
    r = cyc;
    push(r + 1, K_MISO, 10'd1);
    push(r + 2, K_MISO, 10'd1);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    push(cyc, K_RST, 10'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    frame(10'h3C3, K_ERR);
    release_ss();
    frame(10'h0A5, K_RX);
    release_ss();

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    chk("pending_expectations", 10'(q.size()), 10'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
